irq_sync_aggregator: RTL and testbench



---
 rtl/irq_sync_aggregator_if.sv | 27 ++
 rtl/irq_sync_aggregator.sv | 138 +++++++++++++
 tb/tb_irq_sync_aggregator.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/irq_sync_aggregator_if.sv
// Bundle of source inputs, controls and status outputs for irq_sync_aggregator.
// The master side (pad/register side) drives sources and controls; the
// aggregator (slave) returns pending status and the combined request.
interface irq_sync_aggregator_if #(
    parameter int N      = 4,
    parameter int FILT_W = 4,
    parameter int SRC_W  = 2
);
    logic [N-1:0]      irq_in;
    logic [N-1:0]      mode;
    logic [N-1:0]      mask;
    logic [N-1:0]      clr;
    logic [FILT_W-1:0] filt_len;
    logic [N-1:0]      pending;
    logic              irq_out;
    logic [SRC_W-1:0]  irq_src;

    modport master (
        output irq_in, mode, mask, clr, filt_len,
        input  pending, irq_out, irq_src
    );

    modport slave (
        input  irq_in, mode, mask, clr, filt_len,
        output pending, irq_out, irq_src
    );
endinterface

// File: rtl/irq_sync_aggregator.sv
// Interrupt source aggregator: per-source synchronizer, glitch filter,
// edge/level qualification with sticky pending, mask, and a registered
// combined request plus lowest-numbered active source index.
module irq_sync_aggregator #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4,
    parameter int SRC_W       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    irq_sync_aggregator_if.slave  bus
);

    logic [N-1:0]      sync_r [SYNC_STAGES];
    logic [N-1:0]      sync_s;
    logic [N-1:0]      filt_r;
    logic [N-1:0]      filt_nxt_s;
    logic [FILT_W-1:0] cnt_r     [N];
    logic [FILT_W-1:0] cnt_nxt_s [N];
    logic [N-1:0]      filt_d_r;
    logic [N-1:0]      set_s;
    logic [N-1:0]      pending_r;
    logic [N-1:0]      pending_nxt_s;
    logic [N-1:0]      active_s;
    logic              irq_out_r;
    logic [SRC_W-1:0]  irq_src_r;

    // Lowest set bit index; returns 0 when nothing is set.
    function automatic logic [SRC_W-1:0] lowest_idx(input logic [N-1:0] v);
        logic [SRC_W-1:0] idx;
        idx = {SRC_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = SRC_W'(i);
            end
        end
        return idx;
    endfunction

    assign sync_s   = sync_r[SYNC_STAGES-1];
    assign set_s    = filt_r & ~filt_d_r;
    assign active_s = pending_r & bus.mask;

    // Metastability synchronizer chain for the raw source levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int st = 0; st < SYNC_STAGES; st++) begin
                sync_r[st] <= {N{1'b0}};
            end
        end else begin
            sync_r[0] <= bus.irq_in;
            for (int st = 1; st < SYNC_STAGES; st++) begin
                sync_r[st] <= sync_r[st-1];
            end
        end
    end

    // Glitch filter next state: a change must hold L+1 cycles to be accepted.
    // The >= compare lets a shortened filter length finish a running count.
    always_comb begin
        filt_nxt_s = filt_r;
        for (int i = 0; i < N; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (sync_s[i] == filt_r[i]) begin
                cnt_nxt_s[i] = {FILT_W{1'b0}};
            end else if (cnt_r[i] >= bus.filt_len) begin
                filt_nxt_s[i] = sync_s[i];
                cnt_nxt_s[i]  = {FILT_W{1'b0}};
            end else if (cnt_r[i] != {FILT_W{1'b1}}) begin
                cnt_nxt_s[i] = cnt_r[i] + {{(FILT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // Filter state registers; filt_d_r tracks the filtered level in every mode
    // so switching to edge mode while high never fakes a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_r   <= {N{1'b0}};
            filt_d_r <= {N{1'b0}};
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= {FILT_W{1'b0}};
            end
        end else begin
            filt_r   <= filt_nxt_s;
            filt_d_r <= filt_r;
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Pending next state: sticky on rising edge (set beats clear) or level follow.
    always_comb begin
        pending_nxt_s = pending_r;
        for (int i = 0; i < N; i++) begin
            if (bus.mode[i]) begin
                if (set_s[i]) begin
                    pending_nxt_s[i] = 1'b1;
                end else if (bus.clr[i]) begin
                    pending_nxt_s[i] = 1'b0;
                end else begin
                    pending_nxt_s[i] = pending_r[i];
                end
            end else begin
                pending_nxt_s[i] = filt_r[i];
            end
        end
    end

    // Pending status register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= {N{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Registered combined request and lowest masked pending source index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_out_r <= 1'b0;
            irq_src_r <= {SRC_W{1'b0}};
        end else begin
            irq_out_r <= |active_s;
            irq_src_r <= lowest_idx(active_s);
        end
    end

    assign bus.pending = pending_r;
    assign bus.irq_out = irq_out_r;
    assign bus.irq_src = irq_src_r;

endmodule

// File: tb/tb_irq_sync_aggregator.sv
// Directed bench for irq_sync_aggregator (N=4, SYNC_STAGES=2, FILT_W=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_irq_sync_aggregator;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    irq_sync_aggregator_if #(.N(4), .FILT_W(4), .SRC_W(2)) bus ();

    irq_sync_aggregator #(
        .N(4), .SYNC_STAGES(2), .FILT_W(4), .SRC_W(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running block clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] all_out();
        return {25'd0, bus.pending, bus.irq_out, bus.irq_src};
    endfunction

    // Directed stimulus sequence.
    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        bus.irq_in   = 4'b0000;
        bus.mode     = 4'b0000;
        bus.mask     = 4'b1111;
        bus.clr      = 4'b0000;
        bus.filt_len = 4'd0;

        // Reset then idle
        tick(3);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_eq("idle_outputs", all_out(), 32'd0);
        end

        // Edge mode source 1, L=0: pending at k+3, irq_out at k+4
        bus.mode   = 4'b0010;
        bus.irq_in = 4'b0010;
        tick(3);
        check_eq("edge_pend_early", {28'd0, bus.pending}, 32'h0);
        tick(1);
        check_eq("edge_pend_k3", {28'd0, bus.pending}, 32'h2);
        check_eq("edge_irq_k3", {31'd0, bus.irq_out}, 32'h0);
        tick(1);
        check_eq("edge_irq_k4", {31'd0, bus.irq_out}, 32'h1);
        check_eq("edge_src_k4", {30'd0, bus.irq_src}, 32'h1);
        bus.irq_in = 4'b0000;
        tick(6);
        check_eq("edge_sticky", {28'd0, bus.pending}, 32'h2);
        check_eq("edge_sticky_irq", {31'd0, bus.irq_out}, 32'h1);
        bus.clr = 4'b0010;
        tick(1);
        bus.clr = 4'b0000;
        check_eq("clr_pend", {28'd0, bus.pending}, 32'h0);
        check_eq("clr_irq_lag", {31'd0, bus.irq_out}, 32'h1);
        tick(1);
        check_eq("clr_irq", {31'd0, bus.irq_out}, 32'h0);

        // L=3 filter: 3-cycle pulse rejected, 4-cycle pulse accepted
        bus.filt_len = 4'd3;
        bus.irq_in   = 4'b0010;
        tick(3);
        bus.irq_in = 4'b0000;
        tick(10);
        check_eq("short_pulse", {28'd0, bus.pending}, 32'h0);
        bus.irq_in = 4'b0010;
        tick(4);
        bus.irq_in = 4'b0000;
        tick(2);
        check_eq("l3_pend_early", {28'd0, bus.pending}, 32'h0);
        tick(1);
        check_eq("l3_pend_k6", {28'd0, bus.pending}, 32'h2);
        check_eq("l3_irq_k6", {31'd0, bus.irq_out}, 32'h0);
        tick(1);
        check_eq("l3_irq_k7", {31'd0, bus.irq_out}, 32'h1);
        check_eq("l3_src_k7", {30'd0, bus.irq_src}, 32'h1);
        tick(6);
        bus.clr = 4'b0010;
        tick(1);
        bus.clr = 4'b0000;
        tick(2);
        check_eq("l3_cleared", all_out(), 32'd0);
        bus.filt_len = 4'd0;

        // Level mode source 2, L=0
        bus.irq_in = 4'b0100;
        tick(3);
        check_eq("lvl_pend_early", {28'd0, bus.pending}, 32'h0);
        tick(1);
        check_eq("lvl_pend_k3", {28'd0, bus.pending}, 32'h4);
        bus.clr = 4'b0100;
        tick(1);
        bus.clr = 4'b0000;
        check_eq("lvl_clr_ignored", {28'd0, bus.pending}, 32'h4);
        check_eq("lvl_src", {30'd0, bus.irq_src}, 32'h2);
        check_eq("lvl_irq", {31'd0, bus.irq_out}, 32'h1);
        tick(5);
        bus.irq_in = 4'b0000;
        tick(3);
        check_eq("lvl_fall_early", {28'd0, bus.pending}, 32'h4);
        tick(1);
        check_eq("lvl_fall", {28'd0, bus.pending}, 32'h0);

        // Priority and mask with sources 0 and 3 pending
        bus.mode   = 4'b1001;
        bus.mask   = 4'b1001;
        bus.irq_in = 4'b1001;
        tick(5);
        check_eq("prio_pend", {28'd0, bus.pending}, 32'h9);
        check_eq("prio_irq", {31'd0, bus.irq_out}, 32'h1);
        check_eq("prio_src0", {30'd0, bus.irq_src}, 32'h0);
        bus.mask = 4'b1000;
        tick(1);
        check_eq("prio_src3", {30'd0, bus.irq_src}, 32'h3);
        bus.mask = 4'b0000;
        tick(1);
        check_eq("masked_irq", {31'd0, bus.irq_out}, 32'h0);
        check_eq("masked_pend", {28'd0, bus.pending}, 32'h9);
        check_eq("masked_src", {30'd0, bus.irq_src}, 32'h0);
        bus.mask = 4'b1111;
        tick(1);
        check_eq("unmask_irq", {31'd0, bus.irq_out}, 32'h1);
        check_eq("unmask_src", {30'd0, bus.irq_src}, 32'h0);
        bus.irq_in = 4'b0000;

        // Set and clear in the same cycle: set wins
        bus.clr = 4'b1001;
        tick(1);
        bus.clr = 4'b0000;
        check_eq("prio_cleared", {28'd0, bus.pending}, 32'h0);
        tick(4);
        bus.irq_in = 4'b0001;
        tick(3);
        bus.clr = 4'b0001;
        tick(1);
        bus.clr = 4'b0000;
        check_eq("set_wins", {28'd0, bus.pending}, 32'h1);

        // Asynchronous reset mid-run
        tick(1);
        check_eq("pre_rst_irq", {31'd0, bus.irq_out}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst", all_out(), 32'd0);
        bus.irq_in = 4'b0000;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check_eq("post_rst_1", all_out(), 32'd0);
        tick(3);
        check_eq("post_rst_4", all_out(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
